// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - control/status bundle between the multicycle control FSM and the datapath
interface mc_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       alu_ovf;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_write;
    logic       alu_out_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic [3:0] wd_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       epc_write;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct, alu_zero, alu_ovf,
        output pc_write, pc_src, iord, mem_rd, mem_wr, ir_write, alu_out_write,
               reg_write, reg_dst, mem_to_reg, wd_sel, alu_src_a, alu_src_b,
               alu_op, epc_write, state_o
    );

    modport slave (
        output opcode, funct, alu_zero, alu_ovf,
        input  pc_write, pc_src, iord, mem_rd, mem_wr, ir_write, alu_out_write,
               reg_write, reg_dst, mem_to_reg, wd_sel, alu_src_a, alu_src_b,
               alu_op, epc_write, state_o
    );
endinterface

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - Moore control FSM for the multicycle MIPS-subset datapath
module mc_control_fsm #(
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    mc_control_if.master  bus
);
    localparam logic [3:0] ST_RST_SP   = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_EXEC_R   = 4'd3;
    localparam logic [3:0] ST_WB_R     = 4'd4;
    localparam logic [3:0] ST_EXEC_I   = 4'd5;
    localparam logic [3:0] ST_WB_I     = 4'd6;
    localparam logic [3:0] ST_MEM_ADDR = 4'd7;
    localparam logic [3:0] ST_MEM_RD   = 4'd8;
    localparam logic [3:0] ST_WB_MEM   = 4'd9;
    localparam logic [3:0] ST_MEM_WR   = 4'd10;
    localparam logic [3:0] ST_BRANCH   = 4'd11;
    localparam logic [3:0] ST_JUMP     = 4'd12;
    localparam logic [3:0] ST_EXC      = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    logic [3:0] state, state_nxt;
    logic [3:0] cnt;
    logic       cnt_load;
    logic       funct_ok;
    logic       funct_trap;

    assign funct_ok   = (bus.funct == 6'h20) || (bus.funct == 6'h22) || (bus.funct == 6'h24) ||
                        (bus.funct == 6'h25) || (bus.funct == 6'h2A);
    assign funct_trap = (bus.funct == 6'h20) || (bus.funct == 6'h22);

    // The wait counter reloads whenever a memory-read state is freshly entered.
    assign cnt_load = ((state_nxt == ST_FETCH) || (state_nxt == ST_MEM_RD)) && (state_nxt != state);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RST_SP;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (cnt_load)
                cnt <= LAT_M1;
            else if (cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

    always_comb begin
        state_nxt = ST_FETCH;
        case (state)
            ST_RST_SP: state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = (cnt == 4'd0) ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      state_nxt = funct_ok ? ST_EXEC_R : ST_EXC;
                    OP_ADDI:       state_nxt = ST_EXEC_I;
                    OP_LW, OP_SW:  state_nxt = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_nxt = ST_BRANCH;
                    OP_J:          state_nxt = ST_JUMP;
                    default:       state_nxt = ST_EXC;
                endcase
            end
            ST_EXEC_R:   state_nxt = (bus.alu_ovf && funct_trap) ? ST_EXC : ST_WB_R;
            ST_EXEC_I:   state_nxt = bus.alu_ovf ? ST_EXC : ST_WB_I;
            ST_MEM_ADDR: state_nxt = (bus.opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   state_nxt = (cnt == 4'd0) ? ST_WB_MEM : ST_MEM_RD;
            default:     state_nxt = ST_FETCH;
        endcase
    end

    // Outputs are forced low for the whole time reset is held, even though state already reads RST_SP.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_src        = 2'd0;
        bus.iord          = 1'b0;
        bus.mem_rd        = 1'b0;
        bus.mem_wr        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.alu_out_write = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 2'd0;
        bus.mem_to_reg    = 1'b0;
        bus.wd_sel        = 4'd0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.alu_op        = 3'd0;
        bus.epc_write     = 1'b0;
        bus.state_o       = reset_n ? state : 4'd0;
        if (reset_n) begin
            case (state)
                ST_RST_SP: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 2'd2;
                    bus.wd_sel    = 4'd2;
                end
                ST_FETCH: begin
                    bus.mem_rd = 1'b1;
                    if (cnt == 4'd0) begin
                        bus.ir_write  = 1'b1;
                        bus.pc_write  = 1'b1;
                        bus.alu_src_b = 2'd1;
                        bus.alu_op    = ALU_ADD;
                    end
                end
                ST_DECODE: begin
                    bus.alu_src_b     = 2'd3;
                    bus.alu_op        = ALU_ADD;
                    bus.alu_out_write = 1'b1;
                end
                ST_EXEC_R: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_out_write = 1'b1;
                    case (bus.funct)
                        6'h20:   bus.alu_op = ALU_ADD;
                        6'h22:   bus.alu_op = ALU_SUB;
                        6'h24:   bus.alu_op = ALU_AND;
                        6'h25:   bus.alu_op = ALU_OR;
                        6'h2A:   bus.alu_op = ALU_SLT;
                        default: bus.alu_op = 3'd0;
                    endcase
                end
                ST_WB_R: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 2'd1;
                end
                ST_EXEC_I, ST_MEM_ADDR: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_src_b     = 2'd2;
                    bus.alu_op        = ALU_ADD;
                    bus.alu_out_write = 1'b1;
                end
                ST_WB_I: bus.reg_write = 1'b1;
                ST_MEM_RD: begin
                    bus.iord   = 1'b1;
                    bus.mem_rd = 1'b1;
                end
                ST_WB_MEM: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                    bus.wd_sel     = 4'd1;
                end
                ST_MEM_WR: begin
                    bus.iord   = 1'b1;
                    bus.mem_wr = 1'b1;
                end
                ST_BRANCH: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALU_SUB;
                    bus.pc_src    = 2'd1;
                    bus.pc_write  = ((bus.opcode == OP_BEQ) &&  bus.alu_zero) ||
                                    ((bus.opcode == OP_BNE) && !bus.alu_zero);
                end
                ST_JUMP: begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = 2'd2;
                end
                ST_EXC: begin
                    bus.epc_write = 1'b1;
                    bus.pc_write  = 1'b1;
                    bus.pc_src    = 2'd3;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm
module tb_mc_control_fsm;
    localparam int M = 2;

    localparam logic [3:0] S_RST = 4'd0,  S_FETCH = 4'd1,  S_DEC = 4'd2,   S_EXR = 4'd3;
    localparam logic [3:0] S_WBR = 4'd4,  S_EXI = 4'd5,    S_WBI = 4'd6,   S_MA  = 4'd7;
    localparam logic [3:0] S_MRD = 4'd8,  S_WBM = 4'd9,    S_MWR = 4'd10,  S_BR  = 4'd11;
    localparam logic [3:0] S_J   = 4'd12, S_EXC = 4'd13;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_write;
        logic       alu_out_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        logic [3:0] wd_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       epc_write;
    } ctl_t;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_fail;
    ctl_t sb[$];

    mc_control_if bus ();

    mc_control_fsm #(.MEM_LAT(M)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t sample();
        ctl_t v;
        v.st = bus.state_o;             v.pc_write = bus.pc_write;   v.pc_src = bus.pc_src;
        v.iord = bus.iord;              v.mem_rd = bus.mem_rd;       v.mem_wr = bus.mem_wr;
        v.ir_write = bus.ir_write;      v.alu_out_write = bus.alu_out_write;
        v.reg_write = bus.reg_write;    v.reg_dst = bus.reg_dst;     v.mem_to_reg = bus.mem_to_reg;
        v.wd_sel = bus.wd_sel;          v.alu_src_a = bus.alu_src_a; v.alu_src_b = bus.alu_src_b;
        v.alu_op = bus.alu_op;          v.epc_write = bus.epc_write;
        return v;
    endfunction

    // Expected output word for one cycle in state s; flag = last fetch cycle or branch taken.
    function automatic ctl_t ev(input logic [3:0] s, input logic flag, input logic [5:0] fn);
        ctl_t v;
        v = '0;
        v.st = s;
        case (s)
            S_RST:   begin v.reg_write = 1; v.reg_dst = 2; v.wd_sel = 2; end
            S_FETCH: begin
                v.mem_rd = 1;
                if (flag) begin v.ir_write = 1; v.pc_write = 1; v.alu_src_b = 1; v.alu_op = 1; end
            end
            S_DEC:   begin v.alu_src_b = 3; v.alu_op = 1; v.alu_out_write = 1; end
            S_EXR:   begin
                v.alu_src_a = 1; v.alu_out_write = 1;
                v.alu_op = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : (fn == 6'h24) ? 3'd3 :
                           (fn == 6'h25) ? 3'd4 : 3'd5;
            end
            S_WBR:   begin v.reg_write = 1; v.reg_dst = 1; end
            S_EXI, S_MA: begin v.alu_src_a = 1; v.alu_src_b = 2; v.alu_op = 1; v.alu_out_write = 1; end
            S_WBI:   v.reg_write = 1;
            S_MRD:   begin v.iord = 1; v.mem_rd = 1; end
            S_WBM:   begin v.reg_write = 1; v.mem_to_reg = 1; v.wd_sel = 1; end
            S_MWR:   begin v.iord = 1; v.mem_wr = 1; end
            S_BR:    begin v.alu_src_a = 1; v.alu_op = 2; v.pc_src = 1; v.pc_write = flag; end
            S_J:     begin v.pc_write = 1; v.pc_src = 2; end
            S_EXC:   begin v.epc_write = 1; v.pc_write = 1; v.pc_src = 3; end
            default: ;
        endcase
        return v;
    endfunction

    task automatic push_fetch_decode();
        for (int i = 0; i < M; i++) sb.push_back(ev(S_FETCH, i == M - 1, 6'h0));
        sb.push_back(ev(S_DEC, 1'b0, 6'h0));
    endtask

    task automatic test_reset();
        ctl_t got, e;
        reset_n = 1'b0;
        bus.opcode = 6'h0; bus.funct = 6'h0; bus.alu_zero = 1'b0; bus.alu_ovf = 1'b0;
        @(negedge clk); #1;
        got = sample(); n_cmp++;
        if (got !== ctl_t'(0)) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", got, ctl_t'(0)); end
        @(negedge clk);
        bus.opcode = 6'h02;
        reset_n = 1'b1;
        #1;
        sb.push_back(ev(S_RST, 1'b0, 6'h0));
        push_fetch_decode();
        sb.push_back(ev(S_J, 1'b0, 6'h0));
        while (sb.size() != 0) begin
            e = sb.pop_front(); got = sample(); n_cmp++;
            if (got !== e) begin n_fail++; $display("FAIL reset_seq: got %h expected %h", got, e); end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_r_type();
        ctl_t got, e;
        logic [5:0] fl [0:7];
        logic       ov [0:7];
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h24, 6'h25, 6'h2A};
        ov = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            bus.opcode = 6'h00; bus.funct = fl[i]; bus.alu_ovf = ov[i];
            push_fetch_decode();
            sb.push_back(ev(S_EXR, 1'b0, fl[i]));
            sb.push_back(ev(S_WBR, 1'b0, 6'h0));
            while (sb.size() != 0) begin
                e = sb.pop_front(); got = sample(); n_cmp++;
                if (got !== e) begin n_fail++; $display("FAIL r_type funct=%h: got %h expected %h", fl[i], got, e); end
                @(negedge clk); #1;
            end
        end
        bus.alu_ovf = 1'b0;
    endtask

    task automatic test_addi();
        ctl_t got, e;
        for (int i = 0; i < 2; i++) begin
            bus.opcode = 6'h08; bus.alu_ovf = (i == 1);
            push_fetch_decode();
            sb.push_back(ev(S_EXI, 1'b0, 6'h0));
            sb.push_back(ev((i == 1) ? S_EXC : S_WBI, 1'b0, 6'h0));
            while (sb.size() != 0) begin
                e = sb.pop_front(); got = sample(); n_cmp++;
                if (got !== e) begin n_fail++; $display("FAIL addi ovf=%0d: got %h expected %h", i, got, e); end
                @(negedge clk); #1;
            end
        end
        bus.alu_ovf = 1'b0;
    endtask

    task automatic test_lw_sw();
        ctl_t got, e;
        for (int i = 0; i < 2; i++) begin
            bus.opcode = (i == 0) ? 6'h23 : 6'h2B;
            bus.alu_ovf = 1'b1; bus.alu_zero = 1'b1;
            push_fetch_decode();
            sb.push_back(ev(S_MA, 1'b0, 6'h0));
            if (i == 0) begin
                for (int k = 0; k < M; k++) sb.push_back(ev(S_MRD, 1'b0, 6'h0));
                sb.push_back(ev(S_WBM, 1'b0, 6'h0));
            end else begin
                sb.push_back(ev(S_MWR, 1'b0, 6'h0));
            end
            while (sb.size() != 0) begin
                e = sb.pop_front(); got = sample(); n_cmp++;
                if (got !== e) begin n_fail++; $display("FAIL mem op=%h: got %h expected %h", bus.opcode, got, e); end
                @(negedge clk); #1;
            end
        end
        bus.alu_ovf = 1'b0; bus.alu_zero = 1'b0;
    endtask

    task automatic test_branch();
        ctl_t got, e;
        logic taken;
        for (int i = 0; i < 4; i++) begin
            bus.opcode = (i < 2) ? 6'h04 : 6'h05;
            bus.alu_zero = i[0];
            taken = (i < 2) ? i[0] : !i[0];
            push_fetch_decode();
            sb.push_back(ev(S_BR, taken, 6'h0));
            while (sb.size() != 0) begin
                e = sb.pop_front(); got = sample(); n_cmp++;
                if (got !== e) begin n_fail++; $display("FAIL branch op=%h z=%0d: got %h expected %h", bus.opcode, i[0], got, e); end
                @(negedge clk); #1;
            end
        end
        bus.alu_zero = 1'b0;
    endtask

    task automatic test_exceptions();
        ctl_t got, e;
        logic [5:0] op [0:3];
        logic [5:0] fn [0:3];
        op = '{6'h00, 6'h00, 6'h3F, 6'h00};
        fn = '{6'h20, 6'h22, 6'h20, 6'h03};
        for (int i = 0; i < 4; i++) begin
            bus.opcode = op[i]; bus.funct = fn[i]; bus.alu_ovf = 1'b1;
            push_fetch_decode();
            if (i < 2) sb.push_back(ev(S_EXR, 1'b0, fn[i]));
            sb.push_back(ev(S_EXC, 1'b0, 6'h0));
            while (sb.size() != 0) begin
                e = sb.pop_front(); got = sample(); n_cmp++;
                if (got !== e) begin n_fail++; $display("FAIL exc case=%0d: got %h expected %h", i, got, e); end
                @(negedge clk); #1;
            end
        end
        bus.alu_ovf = 1'b0;
    endtask

    task automatic test_reset_mid();
        ctl_t got, e;
        for (int i = 0; i < 2; i++) begin
            bus.opcode = (i == 0) ? 6'h2B : 6'h23;
            if (i == 0) push_fetch_decode();
            sb.push_back(ev(S_MA, 1'b0, 6'h0));
            while (sb.size() != 0) begin
                e = sb.pop_front(); got = sample(); n_cmp++;
                if (got !== e) begin n_fail++; $display("FAIL rmid_pre case=%0d: got %h expected %h", i, got, e); end
                @(negedge clk); #1;
            end
            e = ev((i == 0) ? S_MWR : S_MRD, 1'b0, 6'h0);
            got = sample(); n_cmp++;
            if (got !== e) begin n_fail++; $display("FAIL rmid_mem case=%0d: got %h expected %h", i, got, e); end
            #2 reset_n = 1'b0;
            #1 got = sample(); n_cmp++;
            if (got !== ctl_t'(0)) begin n_fail++; $display("FAIL rmid_async case=%0d: got %h expected %h", i, got, ctl_t'(0)); end
            @(negedge clk);
            reset_n = 1'b1;
            bus.opcode = (i == 0) ? 6'h23 : 6'h08;
            #1;
            sb.push_back(ev(S_RST, 1'b0, 6'h0));
            push_fetch_decode();
            if (i == 1) begin
                sb.push_back(ev(S_EXI, 1'b0, 6'h0));
                sb.push_back(ev(S_WBI, 1'b0, 6'h0));
            end
            while (sb.size() != 0) begin
                e = sb.pop_front(); got = sample(); n_cmp++;
                if (got !== e) begin n_fail++; $display("FAIL rmid_post case=%0d: got %h expected %h", i, got, e); end
                @(negedge clk); #1;
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_r_type();
        test_addi();
        test_lw_sw();
        test_branch();
        test_exceptions();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
